// File: rtl/dmux8way16_buf_if.sv
// dmux8way16_buf_if: producer/consumer bundle for the 8-way buffered demux.
// Ports: in/sel/bcast/in_valid/in_ready, out0..out7, out_valid/out_ready, accept_cnt.
interface dmux8way16_buf_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in;
    logic [2:0]       sel;
    logic             bcast;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    logic [WIDTH-1:0] out4;
    logic [WIDTH-1:0] out5;
    logic [WIDTH-1:0] out6;
    logic [WIDTH-1:0] out7;
    logic [7:0]       out_valid;
    logic [7:0]       out_ready;
    logic [15:0]      accept_cnt;

    // Producer and consumers drive the block.
    modport master (
        output in, sel, bcast, in_valid, out_ready,
        input  in_ready, out_valid, accept_cnt,
        input  out0, out1, out2, out3, out4, out5, out6, out7
    );

    // The buffered demux itself.
    modport slave (
        input  in, sel, bcast, in_valid, out_ready,
        output in_ready, out_valid, accept_cnt,
        output out0, out1, out2, out3, out4, out5, out6, out7
    );
endinterface

// File: rtl/dmux8way16_buf.sv
// dmux8way16_buf: routes one word to one of 8 single-entry channel buffers, or to all.
// Ports: clk, reset (sync, active-high), bus (slave side of dmux8way16_buf_if).
module dmux8way16_buf #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    dmux8way16_buf_if.slave   bus
);
    logic [WIDTH-1:0] data_q [8];
    logic [7:0]       valid_q;
    logic [15:0]      cnt_q;
    logic [7:0]       wr_ok;
    logic [7:0]       fill;
    logic             ready;
    logic             accept;

    // A channel can take a word if empty or being drained this cycle.
    assign wr_ok = ~valid_q | bus.out_ready;

    // Broadcast is all-or-nothing, so it waits for every channel.
    always_comb begin
        ready = wr_ok[bus.sel];
        if (bus.bcast) begin
            ready = &wr_ok;
        end
    end

    assign accept = bus.in_valid & ready;

    always_comb begin
        fill = 8'h00;
        if (accept) begin
            fill = bus.bcast ? 8'hFF : (8'h01 << bus.sel);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 8'h00;
            cnt_q   <= 16'h0000;
            for (int k = 0; k < 8; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            // Drains clear valid; a fill in the same cycle wins.
            valid_q <= (valid_q & ~bus.out_ready) | fill;
            if (accept) begin
                cnt_q <= cnt_q + 16'd1;
            end
            for (int k = 0; k < 8; k++) begin
                if (fill[k]) begin
                    data_q[k] <= bus.in;
                end
            end
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = valid_q;
    assign bus.accept_cnt = cnt_q;
    assign bus.out0       = data_q[0];
    assign bus.out1       = data_q[1];
    assign bus.out2       = data_q[2];
    assign bus.out3       = data_q[3];
    assign bus.out4       = data_q[4];
    assign bus.out5       = data_q[5];
    assign bus.out6       = data_q[6];
    assign bus.out7       = data_q[7];
endmodule

// File: tb/tb_dmux8way16_buf.sv
// tb_dmux8way16_buf: vector table plus per-channel scoreboard for dmux8way16_buf.
// Ports: none (top-level bench).
module tb_dmux8way16_buf;
    logic clk;
    logic reset;

    dmux8way16_buf_if #(.WIDTH(16)) bus ();

    dmux8way16_buf #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] outs [8];
    assign outs[0] = bus.out0;
    assign outs[1] = bus.out1;
    assign outs[2] = bus.out2;
    assign outs[3] = bus.out3;
    assign outs[4] = bus.out4;
    assign outs[5] = bus.out5;
    assign outs[6] = bus.out6;
    assign outs[7] = bus.out7;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: words expected at each channel, in acceptance order.
    typedef logic [15:0] word_q_t [$];
    word_q_t sbq [8];

    logic        pend;
    logic [15:0] p_in;
    logic [2:0]  p_sel;
    logic        p_bc;

    initial pend = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) sbq[k].delete();
            pend = 1'b0;
        end else begin
            if (pend && (!bus.in_valid || bus.in !== p_in ||
                         bus.sel !== p_sel || bus.bcast !== p_bc)) begin
                n_fail++;
                $display("FAIL producer_rule: offer changed before accept at %0t", $time);
            end
            for (int k = 0; k < 8; k++) begin
                if (bus.out_valid[k] && bus.out_ready[k]) begin
                    if (sbq[k].size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL scb_ch%0d: drained %h with nothing expected", k, outs[k]);
                    end else begin
                        chk($sformatf("scb_ch%0d", k), 32'(outs[k]),
                            32'(sbq[k].pop_front()));
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                for (int k = 0; k < 8; k++) begin
                    if (bus.bcast || bus.sel == 3'(k)) sbq[k].push_back(bus.in);
                end
            end
            pend  = bus.in_valid && !bus.in_ready;
            p_in  = bus.in;
            p_sel = bus.sel;
            p_bc  = bus.bcast;
        end
    end

    typedef struct {
        logic [15:0] din;
        logic [2:0]  sel;
        logic        bc;
        logic        iv;
        logic [7:0]  ordy;
        logic        exp_rdy;
        logic [7:0]  exp_valid;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl [10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Expected out_valid/accept_cnt are the state entering each cycle.
        tbl[0] = '{16'hA5A5, 3'd3, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 16'd0};
        tbl[1] = '{16'h1111, 3'd3, 1'b0, 1'b1, 8'h00, 1'b0, 8'h08, 16'd1};
        tbl[2] = '{16'h1111, 3'd3, 1'b0, 1'b1, 8'h08, 1'b1, 8'h08, 16'd1};
        tbl[3] = '{16'h2222, 3'd5, 1'b0, 1'b1, 8'h00, 1'b1, 8'h08, 16'd2};
        tbl[4] = '{16'hBBBB, 3'd0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h28, 16'd3};
        tbl[5] = '{16'hBBBB, 3'd0, 1'b1, 1'b1, 8'h08, 1'b0, 8'h28, 16'd3};
        tbl[6] = '{16'hBBBB, 3'd0, 1'b1, 1'b1, 8'h20, 1'b1, 8'h20, 16'd3};
        tbl[7] = '{16'h6666, 3'd6, 1'b0, 1'b1, 8'h44, 1'b1, 8'hFF, 16'd4};
        tbl[8] = '{16'h7777, 3'd2, 1'b0, 1'b1, 8'h00, 1'b1, 8'hFB, 16'd5};
        tbl[9] = '{16'h0000, 3'd0, 1'b0, 1'b0, 8'hFF, 1'b1, 8'hFF, 16'd6};

        reset         = 1'b1;
        bus.in        = 16'h0;
        bus.sel       = 3'd0;
        bus.bcast     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 8'h00;
        step();
        step();
        @(negedge clk);
        chk("ready_in_reset", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 32'h00);
        chk("rst_cnt", 32'(bus.accept_cnt), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        for (int k = 0; k < 8; k++) chk($sformatf("rst_out%0d", k), 32'(outs[k]), 32'd0);
        step();

        for (int i = 0; i < 10; i++) begin
            bus.in        = tbl[i].din;
            bus.sel       = tbl[i].sel;
            bus.bcast     = tbl[i].bc;
            bus.in_valid  = tbl[i].iv;
            bus.out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), 32'(bus.in_ready), 32'(tbl[i].exp_rdy));
            chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("v%0d_cnt", i), 32'(bus.accept_cnt), 32'(tbl[i].exp_cnt));
            if (i == 1) chk("out3_first", 32'(outs[3]), 32'hA5A5);
            if (i == 8) chk("out2_retained", 32'(outs[2]), 32'hBBBB);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 8'h00;
        @(negedge clk);
        chk("drained_valid", 32'(bus.out_valid), 32'h00);
        chk("drained_cnt", 32'(bus.accept_cnt), 32'd6);
        chk("out6_hold", 32'(outs[6]), 32'h6666);
        step();

        // Counter wrap: 65535 back-to-back accepts into a draining channel.
        reset = 1'b1;
        step();
        reset         = 1'b0;
        bus.sel       = 3'd0;
        bus.bcast     = 1'b0;
        bus.out_ready = 8'h01;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            bus.in = 16'(i * 7 + 3);
            step();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("cnt_ffff", 32'(bus.accept_cnt), 32'hFFFF);
        step();
        bus.in       = 16'h5A5A;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("cnt_wrap", 32'(bus.accept_cnt), 32'h0);
        step();
        step();
        @(negedge clk);
        for (int k = 0; k < 8; k++)
            chk($sformatf("scb_left%0d", k), 32'(sbq[k].size()), 32'd0);

        // Reset coincides with a broadcast accept.
        step();
        bus.in        = 16'hCCCC;
        bus.bcast     = 1'b1;
        bus.out_ready = 8'hFF;
        bus.in_valid  = 1'b1;
        reset         = 1'b1;
        @(negedge clk);
        chk("rst_bc_ready", 32'(bus.in_ready), 32'd1);
        step();
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 8'h00;
        @(negedge clk);
        chk("rst_bc_valid", 32'(bus.out_valid), 32'h00);
        chk("rst_bc_cnt", 32'(bus.accept_cnt), 32'd0);
        chk("rst_bc_ready2", 32'(bus.in_ready), 32'd1);
        for (int k = 0; k < 8; k++) chk($sformatf("rst_bc_out%0d", k), 32'(outs[k]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
